// File: rtl/spi_slave_pkg.sv
// Shared types and widths for the SPI slave byte interface.
// The optional statistics outputs are enabled by defining SPI_STATS_EN.
package spi_slave_pkg;

  localparam int BYTE_W   = 8;
  localparam int BITCNT_W = 3;
  localparam int STATS_W  = 16;

  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(BYTE_W - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync_2ff.sv
// Multi-stage synchroniser for one asynchronous SPI pin, plus a history flop
// that turns the synchronised level into single-cycle rise/fall strobes.
module spi_sync_2ff #(
  parameter int SYNC_LEN = 2  // legal range 2..3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_LEN-1:0] sync_q;
  logic                hist_q;

  // Clearing to 0 means a pin already low at reset release (CS mid-frame)
  // produces no edge; a pin already high yields a rise that IDLE ignores.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage takes its predecessor's previous value.
      sync_q <= {sync_q[SYNC_LEN-2:0], async_i};
      hist_q <= sync_q[SYNC_LEN-1];
    end
  end

  assign level_o = sync_q[SYNC_LEN-1];
  assign rise_o  =  sync_q[SYNC_LEN-1] & ~hist_q;
  assign fall_o  = ~sync_q[SYNC_LEN-1] &  hist_q;

endmodule

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave front-end: oversampled pins, MSB-first byte (de)serialiser
// with valid/ready byte streams. Define SPI_STATS_EN to add frame/overrun counters.
module spi_slave_byte_if
  import spi_slave_pkg::*;
#(
  parameter logic [BYTE_W-1:0] TX_IDLE  = 8'hFF,
  parameter int                SYNC_LEN = 2
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSCLK,
  input  logic              iMOSI,
  input  logic              iCS,
  output logic              oMISO,
  output logic [BYTE_W-1:0] oRX_DATA,
  output logic              oRX_VALID,
  input  logic              iRX_READY,
  input  logic [BYTE_W-1:0] iTX_DATA,
  input  logic              iTX_VALID,
  output logic              oTX_READY,
  output logic              oSOF,
  output logic              oEOF,
  output logic              oOVERRUN,
  output logic              oUNDERRUN
`ifdef SPI_STATS_EN
  ,
  output logic [STATS_W-1:0] oFRAME_CNT,
  output logic [STATS_W-1:0] oOVR_CNT
`endif
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl,   cs_rise,   cs_fall;

  spi_sync_2ff #(.SYNC_LEN(SYNC_LEN)) u_sync_sclk (
    .clk_i(iCLK), .reset_i(iRESET), .async_i(iSCLK),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_2ff #(.SYNC_LEN(SYNC_LEN)) u_sync_mosi (
    .clk_i(iCLK), .reset_i(iRESET), .async_i(iMOSI),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  spi_sync_2ff #(.SYNC_LEN(SYNC_LEN)) u_sync_cs (
    .clk_i(iCLK), .reset_i(iRESET), .async_i(iCS),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, sclk_lvl, mosi_rise, mosi_fall, cs_lvl};

  state_e              state_q;
  logic [BITCNT_W-1:0] bitcnt_q;
  logic [BYTE_W-2:0]   rx_shift_q;
  logic [BYTE_W-1:0]   tx_shift_q;
  logic                done_q;
  logic [BYTE_W-1:0]   done_byte_q;
  logic [BYTE_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                tx_ready_q, sof_q, eof_q, ovr_q, udr_q;

  logic [BYTE_W-1:0]   rx_byte_d;
  logic [BYTE_W-1:0]   tx_load_d;

  assign rx_byte_d = {rx_shift_q, mosi_lvl};
  assign tx_load_d = iTX_VALID ? iTX_DATA : TX_IDLE;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= TX_IDLE;
      done_q      <= 1'b0;
      done_byte_q <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      ovr_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      // NOTE: every pulse is defaulted low first, so each one lasts exactly one cycle.
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      tx_ready_q <= 1'b0;
      udr_q      <= 1'b0;
      ovr_q      <= 1'b0;
      done_q     <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q    <= ACTIVE;
            sof_q      <= 1'b1;
            bitcnt_q   <= '0;
            tx_shift_q <= tx_load_d;
            tx_ready_q <= iTX_VALID;
            udr_q      <= ~iTX_VALID;
          end
        end
        ACTIVE: begin
          // CS is tested first so a coincident SCLK edge is dropped.
          if (cs_rise) begin
            state_q  <= IDLE;
            eof_q    <= 1'b1;
            bitcnt_q <= '0;
          end else if (sclk_rise) begin
            rx_shift_q <= rx_byte_d[BYTE_W-2:0];
            bitcnt_q   <= bitcnt_q + BITCNT_W'(1);
            if (bitcnt_q == LAST_BIT) begin
              done_q      <= 1'b1;
              done_byte_q <= rx_byte_d;
            end
          end else if (sclk_fall) begin
            if (bitcnt_q == '0) begin
              tx_shift_q <= tx_load_d;
              tx_ready_q <= iTX_VALID;
              udr_q      <= ~iTX_VALID;
            end else begin
              tx_shift_q <= {tx_shift_q[BYTE_W-2:0], 1'b0};
            end
          end
        end
      endcase

      // Output stage: a completed byte either replaces/fills the holding
      // register or, if the held byte is still unaccepted, is dropped.
      if (done_q) begin
        if (rx_valid_q && !iRX_READY) begin
          ovr_q <= 1'b1;
        end else begin
          rx_data_q  <= done_byte_q;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && iRX_READY) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign oMISO     = (state_q == ACTIVE) && tx_shift_q[BYTE_W-1];
  assign oRX_DATA  = rx_data_q;
  assign oRX_VALID = rx_valid_q;
  assign oTX_READY = tx_ready_q;
  assign oSOF      = sof_q;
  assign oEOF      = eof_q;
  assign oOVERRUN  = ovr_q;
  assign oUNDERRUN = udr_q;

`ifdef SPI_STATS_EN
  logic [STATS_W-1:0] frame_cnt_q, ovr_cnt_q;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      if (eof_q && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + STATS_W'(1);
      if (ovr_q && (ovr_cnt_q   != '1)) ovr_cnt_q   <= ovr_cnt_q   + STATS_W'(1);
    end
  end

  assign oFRAME_CNT = frame_cnt_q;
  assign oOVR_CNT   = ovr_cnt_q;
`endif

endmodule
